// File: rtl/cplx_var_delay.sv
// Complex (re/im) sample delay line backed by a circular buffer that wraps at the active depth D.
// Optional feature macro CPLX_VAR_DELAY_DYN_LEN_EN: when defined, dly_len selects D at run time; otherwise D = MAX_DEPTH.
module cplx_var_delay #(
    parameter int DATA_W    = 16,
    parameter int MAX_DEPTH = 64,
    parameter int LEN_W     = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [LEN_W-1:0]         dly_len,
    input  logic signed [DATA_W-1:0] x_in_re,
    input  logic signed [DATA_W-1:0] x_in_im,
    output logic signed [DATA_W-1:0] x_out_re,
    output logic signed [DATA_W-1:0] x_out_im,
    output logic                     out_valid,
    output logic [LEN_W-1:0]         fill
);
    localparam int PTR_W = $clog2(MAX_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_MAX = LEN_W'(MAX_DEPTH);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    logic [LEN_W-1:0] d_d;
    logic             clear_s;

`ifdef CPLX_VAR_DELAY_DYN_LEN_EN
    logic [LEN_W-1:0] d_q;
    logic             first_q;
    logic             first_d;

    // Clamp the requested delay into 1..MAX_DEPTH.
    always_comb begin
        first_d = 1'b0;
        if (dly_len == LEN_W'(0)) begin
            d_d = ONE;
        end else if (dly_len > DEPTH_MAX) begin
            d_d = DEPTH_MAX;
        end else begin
            d_d = dly_len;
        end
    end

    // The first edge out of reset adopts dly_len without treating it as a length change.
    assign clear_s = flush | (~first_q & (d_d != d_q));

    // Registered delay and first-edge marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= ONE;
            first_q <= 1'b1;
        end else begin
            d_q     <= d_d;
            first_q <= first_d;
        end
    end
`else
    logic unused_dly_len_s;
    assign unused_dly_len_s = ^dly_len;
    assign d_d              = DEPTH_MAX;
    assign clear_s          = flush;
`endif

    logic [2*DATA_W-1:0]      buf_mem [MAX_DEPTH];
    logic [PTR_W-1:0]         wp_q, wp_d, wp_adv_s;
    logic [LEN_W-1:0]         fill_q, fill_d;
    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] re_q, re_d, im_q, im_d;
    logic [2*DATA_W-1:0]      tap_s;
    logic                     wr_en_s;

    // The slot after the write pointer holds the sample accepted D-1 accepts ago; D=1 bypasses the buffer.
    always_comb begin
        if (LEN_W'(wp_q) == (d_d - ONE)) begin
            wp_adv_s = PTR_W'(0);
        end else begin
            wp_adv_s = wp_q + PTR_W'(1);
        end
        if (d_d == ONE) begin
            tap_s = {x_in_re, x_in_im};
        end else begin
            tap_s = buf_mem[wp_adv_s];
        end
    end

    // Next-state for pointer, fill level, valid flag and output sample.
    always_comb begin
        wp_d    = wp_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        re_d    = re_q;
        im_d    = im_q;
        wr_en_s = 1'b0;
        if (clear_s) begin
            wp_d    = PTR_W'(0);
            fill_d  = LEN_W'(0);
            valid_d = 1'b0;
            re_d    = DATA_W'(0);
            im_d    = DATA_W'(0);
        end else if (enable) begin
            wr_en_s = 1'b1;
            wp_d    = wp_adv_s;
            if (fill_q < d_d) begin
                fill_d = fill_q + ONE;
            end else begin
                fill_d = fill_q;
            end
            valid_d = (fill_d == d_d);
            // Gate the tap so stale buffer contents never reach the outputs.
            if (valid_d) begin
                re_d = tap_s[2*DATA_W-1:DATA_W];
                im_d = tap_s[DATA_W-1:0];
            end else begin
                re_d = DATA_W'(0);
                im_d = DATA_W'(0);
            end
        end else begin
            wp_d = wp_q;
        end
    end

    // Sample storage; contents are masked by the valid logic so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_mem[wp_q] <= {x_in_re, x_in_im};
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= PTR_W'(0);
            fill_q  <= LEN_W'(0);
            valid_q <= 1'b0;
            re_q    <= DATA_W'(0);
            im_q    <= DATA_W'(0);
        end else begin
            wp_q    <= wp_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign x_out_re  = re_q;
    assign x_out_im  = im_q;
    assign out_valid = valid_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_cplx_var_delay.sv
// Self-checking bench for cplx_var_delay: directed scenarios then random traffic against a queue-based model.
module tb_cplx_var_delay;
    localparam int DW = 16;
    localparam int MD = 64;
    localparam int LW = 7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 flush;
    logic [LW-1:0]        dly_len;
    logic signed [DW-1:0] x_in_re, x_in_im;
    logic signed [DW-1:0] x_out_re, x_out_im;
    logic                 out_valid;
    logic [LW-1:0]        fill;

    int vec  = 0;
    int miss = 0;

    // History of accepted samples since the last clear, trimmed to the newest D entries.
    logic [2*DW-1:0] hist [$];
    int              m_d;
    bit              m_first;

    cplx_var_delay #(.DATA_W(DW), .MAX_DEPTH(MD), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .dly_len(dly_len),
        .x_in_re(x_in_re), .x_in_im(x_in_im), .x_out_re(x_out_re), .x_out_im(x_out_im),
        .out_valid(out_valid), .fill(fill)
    );

    always #5 clk = ~clk;

`ifdef CPLX_VAR_DELAY_DYN_LEN_EN
    function automatic int clamp(input int len);
        if (len == 0) return 1;
        if (len > MD) return MD;
        return len;
    endfunction
`endif

    task automatic model_reset();
        hist.delete();
        m_first = 1'b1;
`ifdef CPLX_VAR_DELAY_DYN_LEN_EN
        m_d = 1;
`else
        m_d = MD;
`endif
    endtask

    task automatic model_edge();
        int dn;
        bit chg;
`ifdef CPLX_VAR_DELAY_DYN_LEN_EN
        dn  = clamp(int'(dly_len));
        chg = !m_first && (dn != m_d);
`else
        dn  = MD;
        chg = 1'b0;
`endif
        m_first = 1'b0;
        m_d     = dn;
        if (flush || chg) begin
            hist.delete();
        end else if (enable) begin
            hist.push_back({x_in_re, x_in_im});
            if (hist.size() > m_d) hist.delete(0);
        end
    endtask

    task automatic check(input string tag);
        logic signed [DW-1:0] er, ei;
        logic                 ev;
        logic [LW-1:0]        ef;
        ev = (hist.size() == m_d);
        ef = LW'(hist.size());
        er = '0;
        ei = '0;
        if (ev) begin
            er = hist[0][2*DW-1:DW];
            ei = hist[0][DW-1:0];
        end
        vec++;
        assert (x_out_re === er) else begin
            miss++;
            $error("FAIL %s x_out_re observed %0d expected %0d", tag, x_out_re, er);
        end
        vec++;
        assert (x_out_im === ei) else begin
            miss++;
            $error("FAIL %s x_out_im observed %0d expected %0d", tag, x_out_im, ei);
        end
        vec++;
        assert (out_valid === ev) else begin
            miss++;
            $error("FAIL %s out_valid observed %0b expected %0b", tag, out_valid, ev);
        end
        vec++;
        assert (fill === ef) else begin
            miss++;
            $error("FAIL %s fill observed %0d expected %0d", tag, fill, ef);
        end
    endtask

    task automatic step(input bit en, input bit fl, input int len, input int re, input int im,
                        input string tag);
        enable  = en;
        flush   = fl;
        dly_len = LW'(len);
        x_in_re = DW'(re);
        x_in_im = DW'(im);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        int len;
        bit pat [7];
        rst_n   = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        dly_len = LW'(4);
        x_in_re = '0;
        x_in_im = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset");
        @(negedge clk) rst_n = 1'b1;

        // D=4 ramp with im = -re.
        for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 4, i, -i, "d4_ramp");

        // D=1 pass-through.
        step(1'b1, 1'b0, 1, 5, 0, "d1_change");
        step(1'b1, 1'b0, 1, 7, -7, "d1_first");
        step(1'b1, 1'b0, 1, 9, -9, "d1_second");

        // D=3 with gaps in enable.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        step(1'b1, 1'b0, 3, 0, 0, "d3_change");
        for (int i = 0; i < 7; i++) step(pat[i], 1'b0, 3, 10 + i, 100 + i, "d3_gaps");

        // D=5 flush wins over a simultaneous accept.
        step(1'b1, 1'b0, 5, 0, 0, "d5_change");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5, 20 + i, -20 - i, "d5_stream");
        step(1'b1, 1'b1, 5, 99, 99, "d5_flush");
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 5, i, -i, "d5_refill");

        // Length changes and clamping.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4, 30 + i, i, "d4_stream");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2, 40 + i, i, "d2_change");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 50 + i, i, "d0_clamp");
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 100, 200 + i, -i, "dbig_clamp");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 127, 300 + i, i, "dmax_same");

        // Asynchronous reset mid-stream at D=6.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6, 400 + i, i, "d6_stream");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(posedge clk);
        #1 check("in_rst");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6, 500 + i, -i, "d6_after_rst");

        // Random traffic.
        len = 6;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) len = int'($urandom_range(0, 127));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, len,
                 int'($urandom), int'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/cplx_var_delay.md
CPLX_VAR_DELAY -- requirements
Module: cplx_var_delay

Interface
REQ-001 Parameter: DATA_W, default 16, width of each signed real/imag sample.
REQ-002 Parameter: MAX_DEPTH, default 64, largest supported delay in accepted samples (>=2).
REQ-003 Parameter: LEN_W, default 7, width of dly_len; SHALL be >= clog2(MAX_DEPTH+1).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: enable  in  1  sample strobe; an input sample is accepted on each clk edge with enable=1.
REQ-007 Port: flush  in  1  synchronous clear of delay history.
REQ-008 Port: dly_len  in  LEN_W  requested delay D, in accepted samples.
REQ-009 Port: x_in_re / x_in_im  in  DATA_W each  signed input sample.
REQ-010 Port: x_out_re / x_out_im  out  DATA_W each  signed delayed sample, registered.
REQ-011 Port: out_valid  out  1  high when x_out holds a genuinely delayed sample.
REQ-012 Port: fill  out  LEN_W  number of valid samples in history, saturating at D.

Function
REQ-013 Effective delay D = dly_len clamped to 1..MAX_DEPTH (0 -> 1; >MAX_DEPTH -> MAX_DEPTH).
REQ-014 Number accepted samples s0, s1, ... from the last reset/flush/length change; after the edge accepting sn, x_out SHALL equal s(n-D+1) (D=1: x_out = sample just accepted).
REQ-015 Storage: circular buffer of MAX_DEPTH entries with wrap at D; not a tap-per-stage shift register.
REQ-016 Edges with enable=0: x_out, out_valid, fill and buffer pointers SHALL hold.
REQ-017 fill increments by 1 per accepted sample until it reaches D, then holds.
REQ-018 out_valid SHALL be 1 after the edge on which fill reaches D, and remain 1 until reset, flush or length change.
REQ-019 While out_valid=0, x_out_re and x_out_im SHALL be 0; stale buffer contents SHALL never reach the outputs.
REQ-020 flush=1 on an edge: fill <- 0, out_valid <- 0, x_out <- 0, pointers <- 0; a sample presented with enable=1 on that edge SHALL be discarded (flush wins).
REQ-021 Length change: the clamped D is registered; if it differs from the previously registered value, the module SHALL behave as a flush on that edge, and a sample presented with enable=1 on that edge SHALL be discarded.
REQ-022 Data SHALL pass bit-exact: no rounding, scaling or sign change.
REQ-023 Throughput: one sample per clock sustained with enable held high; no stall output.

Reset
REQ-024 rst_n low SHALL immediately force x_out_re=0, x_out_im=0, out_valid=0, fill=0, pointers=0, registered D=1.
REQ-025 Buffer memory is not reset; REQ-019 guarantees its contents are unobservable.
REQ-026 Reset asserted mid-stream SHALL discard all history; after release, behaviour SHALL be identical to power-up.
REQ-027 The first edge after rst_n release SHALL register dly_len without a flush side-effect; a sample presented with enable=1 on that edge SHALL be accepted.

Configuration
REQ-028 Macro CPLX_VAR_DELAY_DYN_LEN_EN defined: dly_len is honoured per REQ-013/REQ-021.
REQ-029 Macro CPLX_VAR_DELAY_DYN_LEN_EN undefined: dly_len is ignored; D is fixed at MAX_DEPTH from reset; REQ-021 does not apply.

Verification
REQ-030 D=4; enable=1 continuously; inputs re=1,2,3,...,10, im=-re -> out_valid rises after the 4th sample; outputs (1,-1),(2,-2),...; fill saturates at 4.
REQ-031 D=1; inputs re=7 then re=9 -> x_out_re=7 then 9 on the same edges they are accepted; out_valid=1 after the first accept.
REQ-032 D=3; enable pattern 1,0,0,1,1,0,1 with inputs 10..16 on every clock -> accepted 10,13,14,16; x_out_re=10 appears on the edge accepting 14, holds on the enable=0 edge, then 13 on the edge accepting 16.
REQ-033 D=5; stream 8 samples; flush=1 with enable=1 and re=99 -> out_valid=0, x_out=0, fill=0, 99 discarded; the next 5 accepts re=1..5 -> out_valid=1, x_out_re=1.
REQ-034 D=4 streaming, then dly_len=2 -> behaves as flush, fill=0; out_valid returns after 2 accepts. dly_len=0 -> D=1; dly_len=200 -> D=MAX_DEPTH (64, default).
REQ-035 Assert rst_n low for one clock mid-stream at D=6 -> outputs 0 asynchronously; after release, out_valid rises only after 6 new accepts; repeat the bench with CPLX_VAR_DELAY_DYN_LEN_EN undefined -> D=64 regardless of dly_len.
